// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int N_DIGITS = 4;
  localparam int DIGIT_W  = 4;

  typedef enum logic {
    BLANK,
    SHOW
  } scanState_e;

  function automatic int scan_div(input int clkHz, input int scanHz);
    return clkHz / scanHz;
  endfunction

endpackage

// File: rtl/pulse_divider.sv
// Free-running cycle counter whose output toggles on every terminal count.
module pulse_divider #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic resetN,
  output logic square
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count  <= '0;
      square <= 1'b0;
    end else if (count == TERMINAL) begin
      count  <= '0;
      square <= ~square;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// 4-digit time-multiplexed display scanner with frame-synchronous digit loading.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scanner
  import display_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        loadValid,
  output logic        loadReady,
  input  logic [15:0] loadDigits,
  output logic [1:0]  contDigito,
  output logic [3:0]  valor,
  output logic [3:0]  digitEnable,
  output logic        umSegundo,
  output logic        frameStart
);

  localparam int SCAN_DIV = scan_div(CLK_HZ, SCAN_HZ);
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  logic [CNT_W-1:0] slotCount;
  scanState_e       state;
  logic [15:0]      activeDigits;
  logic [15:0]      pendingDigits;
  logic [3:0]       showEnable;

  function automatic logic [DIGIT_W-1:0] digitOf(input logic [15:0] digits,
                                                 input logic [1:0]  idx);
    return digits[{idx, 2'b00} +: DIGIT_W];
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it is digit 0 or it or any higher digit is non-zero.
  function automatic logic digitLit(input logic [15:0] digits, input logic [1:0] idx);
    logic lit;
    lit = (idx == 2'd0);
    for (int d = 0; d < N_DIGITS; d++)
      if (d >= int'(idx) && digits[d*DIGIT_W +: DIGIT_W] != '0) lit = 1'b1;
    return lit;
  endfunction
`endif

  always_comb begin
    showEnable = ~(4'b0001 << contDigito);
`ifdef LEADING_ZERO_BLANK_EN
    if (!digitLit(activeDigits, contDigito)) showEnable = 4'b1111;
`endif
  end

  pulse_divider #(
    .DIV(CLK_HZ / 2)
  ) blinkDiv (
    .clock (clock),
    .resetN(resetN),
    .square(umSegundo)
  );

  // loadReady doubles as the "pending empty" flag for the pending buffer.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slotCount     <= '0;
      state         <= BLANK;
      contDigito    <= '0;
      valor         <= '0;
      digitEnable   <= 4'b1111;
      frameStart    <= 1'b0;
      loadReady     <= 1'b1;
      activeDigits  <= '0;
      pendingDigits <= '0;
    end else begin
      frameStart <= 1'b0;
      if (loadValid && loadReady) begin
        pendingDigits <= loadDigits;
        loadReady     <= 1'b0;
      end
      case (state)
        BLANK: begin
          slotCount <= slotCount + 1'b1;
          if (slotCount == DEAD_LAST) begin
            state       <= SHOW;
            digitEnable <= showEnable;
          end
        end
        SHOW: begin
          if (slotCount == SLOT_LAST) begin
            slotCount   <= '0;
            state       <= BLANK;
            digitEnable <= 4'b1111;
            contDigito  <= contDigito + 2'd1;
            if (contDigito == 2'd3) begin
              // Frame boundary: a load accepted this very cycle waits a frame.
              frameStart <= 1'b1;
              if (!loadReady) begin
                activeDigits <= pendingDigits;
                loadReady    <= 1'b1;
                valor        <= pendingDigits[DIGIT_W-1:0];
              end else begin
                valor <= activeDigits[DIGIT_W-1:0];
              end
            end else begin
              valor <= digitOf(activeDigits, contDigito + 2'd1);
            end
          end else begin
            slotCount <= slotCount + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (SCAN_DIV = 10, DEAD_CYCLES = 2).
module tb_display_scanner;

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        loadValid = 1'b0;
  logic [15:0] loadDigits = 16'h0;
  logic        loadReady;
  logic [1:0]  contDigito;
  logic [3:0]  valor;
  logic [3:0]  digitEnable;
  logic        umSegundo;
  logic        frameStart;

  int tests = 0;
  int fails = 0;
  int cyc;

  logic [11:0] obs;
  assign obs = {contDigito, valor, digitEnable, frameStart, loadReady};

  display_scanner #(
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .DEAD_CYCLES(2)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .loadValid  (loadValid),
    .loadReady  (loadReady),
    .loadDigits (loadDigits),
    .contDigito (contDigito),
    .valor      (valor),
    .digitEnable(digitEnable),
    .umSegundo  (umSegundo),
    .frameStart (frameStart)
  );

  always #5 clock = ~clock;

  // Rising edges since the last reset release.
  always @(posedge clock or negedge resetN)
    if (!resetN) cyc <= 0;
    else cyc <= cyc + 1;

  // Expected {contDigito, valor, digitEnable, frameStart, loadReady} at frame position j.
  function automatic logic [11:0] expVec(input logic [15:0] d, input int j, input logic ready);
    int slot;
    int cnt;
    logic [3:0] en;
    slot = j / 10;
    cnt  = j % 10;
    en   = ~(4'b0001 << slot);
    if (cnt < 2) en = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0 && (d >> (4 * slot)) == 16'h0) en = 4'b1111;
`endif
    return {slot[1:0], d[4*slot +: 4], en, j == 0, ready};
  endfunction

  task automatic waitFrame(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!frameStart && k < 100);
    if (!frameStart) begin
      tests++; fails++;
      $display("FAIL %s: frameStart not seen within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (contDigito !== 2'd0) begin fails++; $display("FAIL reset contDigito got=%0d exp=0", contDigito); end
    tests++; if (valor !== 4'd0) begin fails++; $display("FAIL reset valor got=%0d exp=0", valor); end
    tests++; if (digitEnable !== 4'b1111) begin fails++; $display("FAIL reset digitEnable got=%b exp=1111", digitEnable); end
    tests++; if (umSegundo !== 1'b0) begin fails++; $display("FAIL reset umSegundo got=%b exp=0", umSegundo); end
    tests++; if (frameStart !== 1'b0) begin fails++; $display("FAIL reset frameStart got=%b exp=0", frameStart); end
    tests++; if (loadReady !== 1'b1) begin fails++; $display("FAIL reset loadReady got=%b exp=1", loadReady); end
    resetN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (digitEnable !== ((k < 2) ? 4'b1111 : 4'b1110)) begin
        fails++; $display("FAIL release_enable k=%0d got=%b exp=%b", k, digitEnable, (k < 2) ? 4'b1111 : 4'b1110);
      end
      @(negedge clock);
    end
    tests++; if (contDigito !== 2'd1) begin fails++; $display("FAIL release_slot1 contDigito got=%0d exp=1", contDigito); end
  endtask

  task automatic test_scan_order();
    loadDigits = 16'h4321; loadValid = 1'b1;
    @(negedge clock);
    loadValid = 1'b0;
    tests++; if (loadReady !== 1'b0) begin fails++; $display("FAIL scan_accept loadReady got=%b exp=0", loadReady); end
    waitFrame("scan_frame");
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h4321, j, 1'b1)) begin fails++; $display("FAIL scan j=%0d got=%h exp=%h", j, obs, expVec(16'h4321, j, 1'b1)); end
      @(negedge clock);
    end
  endtask

  task automatic test_tear_free();
    for (int j = 0; j < 10; j++) begin
      tests++;
      if (obs !== expVec(16'h4321, j, 1'b1)) begin fails++; $display("FAIL tear_pre j=%0d got=%h exp=%h", j, obs, expVec(16'h4321, j, 1'b1)); end
      @(negedge clock);
    end
    loadDigits = 16'h9876; loadValid = 1'b1;
    tests++;
    if (obs !== expVec(16'h4321, 10, 1'b1)) begin fails++; $display("FAIL tear_offer got=%h exp=%h", obs, expVec(16'h4321, 10, 1'b1)); end
    @(negedge clock);
    loadValid = 1'b0;
    for (int j = 11; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h4321, j, 1'b0)) begin fails++; $display("FAIL tear_hold j=%0d got=%h exp=%h", j, obs, expVec(16'h4321, j, 1'b0)); end
      @(negedge clock);
    end
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h9876, j, 1'b1)) begin fails++; $display("FAIL tear_new j=%0d got=%h exp=%h", j, obs, expVec(16'h9876, j, 1'b1)); end
      @(negedge clock);
    end
  endtask

  task automatic test_boundary_load();
    for (int j = 0; j < 39; j++) begin
      tests++;
      if (obs !== expVec(16'h9876, j, 1'b1)) begin fails++; $display("FAIL bnd_pre j=%0d got=%h exp=%h", j, obs, expVec(16'h9876, j, 1'b1)); end
      @(negedge clock);
    end
    loadDigits = 16'h5555; loadValid = 1'b1;
    tests++;
    if (obs !== expVec(16'h9876, 39, 1'b1)) begin fails++; $display("FAIL bnd_offer got=%h exp=%h", obs, expVec(16'h9876, 39, 1'b1)); end
    @(negedge clock);
    loadValid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h9876, j, 1'b0)) begin fails++; $display("FAIL bnd_old j=%0d got=%h exp=%h", j, obs, expVec(16'h9876, j, 1'b0)); end
      @(negedge clock);
    end
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h5555, j, 1'b1)) begin fails++; $display("FAIL bnd_new j=%0d got=%h exp=%h", j, obs, expVec(16'h5555, j, 1'b1)); end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    loadDigits = 16'hAAAA; loadValid = 1'b1;
    tests++;
    if (obs !== expVec(16'h5555, 0, 1'b1)) begin fails++; $display("FAIL bp_first got=%h exp=%h", obs, expVec(16'h5555, 0, 1'b1)); end
    @(negedge clock);
    loadDigits = 16'hBBBB;
    for (int j = 1; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h5555, j, 1'b0)) begin fails++; $display("FAIL bp_wait j=%0d got=%h exp=%h", j, obs, expVec(16'h5555, j, 1'b0)); end
      @(negedge clock);
    end
    tests++;
    if (obs !== expVec(16'hAAAA, 0, 1'b1)) begin fails++; $display("FAIL bp_aaaa got=%h exp=%h", obs, expVec(16'hAAAA, 0, 1'b1)); end
    @(negedge clock);
    loadValid = 1'b0;
    for (int j = 1; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'hAAAA, j, 1'b0)) begin fails++; $display("FAIL bp_aaaa j=%0d got=%h exp=%h", j, obs, expVec(16'hAAAA, j, 1'b0)); end
      @(negedge clock);
    end
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'hBBBB, j, 1'b1)) begin fails++; $display("FAIL bp_bbbb j=%0d got=%h exp=%h", j, obs, expVec(16'hBBBB, j, 1'b1)); end
      @(negedge clock);
    end
  endtask

  task automatic test_mid_reset();
    loadDigits = 16'h1234; loadValid = 1'b1;
    @(negedge clock);
    loadValid = 1'b0;
    tests++; if (loadReady !== 1'b0) begin fails++; $display("FAIL midrst_pending loadReady got=%b exp=0", loadReady); end
    repeat (14) @(negedge clock);
    tests++;
    if (obs !== expVec(16'hBBBB, 15, 1'b0)) begin fails++; $display("FAIL midrst_before got=%h exp=%h", obs, expVec(16'hBBBB, 15, 1'b0)); end
    #2 resetN = 1'b0;
    #1;
    tests++;
    if (obs !== 12'b00_0000_1111_0_1) begin fails++; $display("FAIL midrst_async got=%h exp=%h", obs, 12'b00_0000_1111_0_1); end
    tests++; if (umSegundo !== 1'b0) begin fails++; $display("FAIL midrst_blink umSegundo got=%b exp=0", umSegundo); end
    @(negedge clock);
    resetN = 1'b1;
    waitFrame("midrst_frame");
    tests++;
    if (obs !== expVec(16'h0000, 0, 1'b1)) begin fails++; $display("FAIL midrst_discard got=%h exp=%h", obs, expVec(16'h0000, 0, 1'b1)); end
  endtask

  task automatic test_blink();
    for (int k = 0; k < 2000 && cyc < 499; k++) @(negedge clock);
    tests++; if (umSegundo !== 1'b0) begin fails++; $display("FAIL blink_499 got=%b exp=0 cyc=%0d", umSegundo, cyc); end
    @(negedge clock);
    tests++; if (umSegundo !== 1'b1) begin fails++; $display("FAIL blink_500 got=%b exp=1 cyc=%0d", umSegundo, cyc); end
    for (int k = 0; k < 2000 && cyc < 999; k++) @(negedge clock);
    tests++; if (umSegundo !== 1'b1) begin fails++; $display("FAIL blink_999 got=%b exp=1 cyc=%0d", umSegundo, cyc); end
    @(negedge clock);
    tests++; if (umSegundo !== 1'b0) begin fails++; $display("FAIL blink_1000 got=%b exp=0 cyc=%0d", umSegundo, cyc); end
  endtask

  task automatic test_leading_zero();
    waitFrame("lz_sync");
    loadDigits = 16'h0070; loadValid = 1'b1;
    tests++;
    if (obs !== expVec(16'h0000, 0, 1'b1)) begin fails++; $display("FAIL lz_offer got=%h exp=%h", obs, expVec(16'h0000, 0, 1'b1)); end
    @(negedge clock);
    loadValid = 1'b0;
    for (int j = 1; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h0000, j, 1'b0)) begin fails++; $display("FAIL lz_zero_old j=%0d got=%h exp=%h", j, obs, expVec(16'h0000, j, 1'b0)); end
      @(negedge clock);
    end
    loadDigits = 16'h0000; loadValid = 1'b1;
    tests++;
    if (obs !== expVec(16'h0070, 0, 1'b1)) begin fails++; $display("FAIL lz_0070 j=0 got=%h exp=%h", obs, expVec(16'h0070, 0, 1'b1)); end
    @(negedge clock);
    loadValid = 1'b0;
    for (int j = 1; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h0070, j, 1'b0)) begin fails++; $display("FAIL lz_0070 j=%0d got=%h exp=%h", j, obs, expVec(16'h0070, j, 1'b0)); end
      @(negedge clock);
    end
    for (int j = 0; j < 40; j++) begin
      tests++;
      if (obs !== expVec(16'h0000, j, 1'b1)) begin fails++; $display("FAIL lz_0000 j=%0d got=%h exp=%h", j, obs, expVec(16'h0000, j, 1'b1)); end
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_boundary_load();
    test_back_to_back();
    test_mid_reset();
    test_blink();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
